// File: rtl/wr_ptr_full_pkg.sv
// wr_ptr_full_pkg: FIFO pointer defaults (ADDR_W, AF_MARGIN) and bin2gray/gray2bin helpers shared by write and read sides
package wr_ptr_full_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int AF_MARGIN_DEF = 2;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) b = b ^ (g >> i);
    return b;
  endfunction
endpackage

// File: rtl/wr_ptr_full_sync_2ff.sv
// sync_2ff: two-flop synchronizer; clk/rst in, d (async, W bits) in, q (synchronized) out, resets to 0
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1;
  always_ff @(posedge clk)
    if (rst) {q, s1} <= '0;
    else {q, s1} <= {s1, d};
endmodule

// File: rtl/wr_ptr_full.sv
// wr_ptr_full: async FIFO write-side pointer/full logic; in wr_clk, wr_rst, wr_req, rd_gptr_async; out mem_wr_en, wr_ptr, wr_gptr, full, almost_full, wr_level, overflow
module wr_ptr_full
  import wr_ptr_full_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int AF_MARGIN = AF_MARGIN_DEF
) (
  input  logic              wr_clk,
  input  logic              wr_rst,
  input  logic              wr_req,
  input  logic [ADDR_W:0]   rd_gptr_async,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W:0]   wr_gptr,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              overflow
);
  localparam int W = ADDR_W + 1;
  localparam int DEPTH = 2 ** ADDR_W;
  logic [ADDR_W:0] wbin, wbin_next, gray_next, rq2_gptr, rq2_bin, level_next;
  logic push, full_next;
  sync_2ff #(.W(W)) u_sync (
    .clk(wr_clk),
    .rst(wr_rst),
    .d  (rd_gptr_async),
    .q  (rq2_gptr)
  );
  always_comb begin
    push = wr_req && !full && !wr_rst;
    wbin_next = wbin + W'(push);
    gray_next = W'(bin2gray(32'(wbin_next)));
    rq2_bin = W'(gray2bin(32'(rq2_gptr)));
    level_next = wbin_next - rq2_bin;
    full_next = gray_next == {~rq2_gptr[ADDR_W:ADDR_W-1], rq2_gptr[ADDR_W-2:0]};
  end
  assign mem_wr_en = push;
  assign wr_ptr = wbin[ADDR_W-1:0];
  always_ff @(posedge wr_clk)
    if (wr_rst) begin
      wbin <= '0;
      wr_gptr <= '0;
      full <= 1'b0;
      almost_full <= 1'b0;
      wr_level <= '0;
      overflow <= 1'b0;
    end else begin
      wbin <= wbin_next;
      wr_gptr <= gray_next;
      full <= full_next;
      almost_full <= level_next >= W'(DEPTH - AF_MARGIN);
      wr_level <= level_next;
      overflow <= overflow | (wr_req & full);
    end
endmodule

// File: tb/tb_wr_ptr_full.sv
// tb_wr_ptr_full: directed scoreboard bench for wr_ptr_full (ADDR_W=4, AF_MARGIN=2)
module tb_wr_ptr_full;
  logic wr_clk = 1'b0;
  logic wr_rst = 1'b1;
  logic wr_req = 1'b0;
  logic [4:0] rd_gptr_async = '0;
  logic mem_wr_en, full, almost_full, overflow;
  logic [3:0] wr_ptr;
  logic [4:0] wr_gptr, wr_level;
  typedef struct {
    string tag;
    logic mwe;
    logic [3:0] ptr;
    logic [4:0] gptr;
    logic [4:0] lvl;
    logic fu;
    logic af;
    logic ov;
  } exp_t;
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  logic [4:0] eb = '0;
  logic [4:0] prev_g = '0;
  wr_ptr_full #(.ADDR_W(4), .AF_MARGIN(2)) dut (
    .wr_clk       (wr_clk),
    .wr_rst       (wr_rst),
    .wr_req       (wr_req),
    .rd_gptr_async(rd_gptr_async),
    .mem_wr_en    (mem_wr_en),
    .wr_ptr       (wr_ptr),
    .wr_gptr      (wr_gptr),
    .full         (full),
    .almost_full  (almost_full),
    .wr_level     (wr_level),
    .overflow     (overflow)
  );
  always #5 wr_clk = ~wr_clk;
  function automatic logic [4:0] g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction
  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] x);
    total++;
    assert (o === x) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
    end
  endtask
  task automatic cyc(input string tag, input logic rst, input logic req, input logic [4:0] rd,
                     input logic acc, input logic [4:0] lvl, input logic fu, input logic af, input logic ov);
    exp_t e;
    logic mwe_o;
    logic [3:0] ptr_o;
    e.tag = tag;
    e.mwe = acc;
    e.ptr = eb[3:0];
    e.gptr = rst ? 5'd0 : g(eb + 5'(acc));
    e.lvl = lvl;
    e.fu = fu;
    e.af = af;
    e.ov = ov;
    sb.push_back(e);
    eb = rst ? 5'd0 : eb + 5'(acc);
    wr_rst = rst;
    wr_req = req;
    rd_gptr_async = rd;
    #1;
    mwe_o = mem_wr_en;
    ptr_o = wr_ptr;
    @(posedge wr_clk);
    @(negedge wr_clk);
    e = sb.pop_front();
    chk({e.tag, ":mem_wr_en"}, 8'(mwe_o), 8'(e.mwe));
    chk({e.tag, ":wr_ptr"}, 8'(ptr_o), 8'(e.ptr));
    chk({e.tag, ":wr_gptr"}, 8'(wr_gptr), 8'(e.gptr));
    chk({e.tag, ":wr_level"}, 8'(wr_level), 8'(e.lvl));
    chk({e.tag, ":full"}, 8'(full), 8'(e.fu));
    chk({e.tag, ":almost_full"}, 8'(almost_full), 8'(e.af));
    chk({e.tag, ":overflow"}, 8'(overflow), 8'(e.ov));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    @(posedge wr_clk);
    @(negedge wr_clk);
    cyc("reset", 1, 1, 5'd0, 0, 5'd0, 0, 0, 0);
    for (int i = 1; i <= 16; i++) cyc("fill", 0, 1, 5'd0, 1, 5'(i), i == 16, i >= 14, 0);
    cyc("overflow", 0, 1, 5'd0, 0, 5'd16, 1, 1, 1);
    cyc("drain", 0, 0, 5'b00001, 0, 5'd16, 1, 1, 1);
    cyc("drain", 0, 0, 5'b00001, 0, 5'd16, 1, 1, 1);
    cyc("drain_rel", 0, 0, 5'b00001, 0, 5'd15, 0, 1, 1);
    cyc("refill", 0, 1, 5'b00001, 1, 5'd16, 1, 1, 1);
    cyc("simul0", 0, 1, g(5'd2), 0, 5'd16, 1, 1, 1);
    cyc("simul1", 0, 1, g(5'd2), 0, 5'd16, 1, 1, 1);
    cyc("simul2", 0, 1, g(5'd2), 0, 5'd15, 0, 1, 1);
    cyc("simul_acc", 0, 1, g(5'd2), 1, 5'd16, 1, 1, 1);
    cyc("lvl9", 0, 0, g(5'd9), 0, 5'd16, 1, 1, 1);
    cyc("lvl9", 0, 0, g(5'd9), 0, 5'd16, 1, 1, 1);
    cyc("lvl9", 0, 0, g(5'd9), 0, 5'd9, 0, 0, 1);
    cyc("reset_mid", 1, 1, 5'd0, 0, 5'd0, 0, 0, 0);
    prev_g = '0;
    for (int k = 0; k < 40; k++) begin
      cyc("wrap", 0, 1, g(eb), 1, k < 2 ? 5'(k + 1) : 5'd3, 0, 0, 0);
      chk("wrap:hamming", 8'($countones(wr_gptr ^ prev_g)), 8'd1);
      prev_g = wr_gptr;
    end
    chk("wrap:final_ptr", 8'(wr_ptr), 8'd8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
